// File: rtl/noc_initiator_if.sv
// noc_initiator_if: host request/data channels plus the NoC transmit/receive flit link.
interface noc_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_dev;
  logic [2:0]  req_reg;
  logic [4:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        resp_done;
  logic        resp_err;
  logic        Firstout;
  logic [63:0] Dout;
  logic        Firstin;
  logic [63:0] Din;
  modport master (
    input  req_valid, req_write, req_dev, req_reg, req_len, wr_valid, wr_data, Firstin, Din,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_done, resp_err, Firstout, Dout
  );
  modport slave (
    output req_valid, req_write, req_dev, req_reg, req_len, wr_valid, wr_data, Firstin, Din,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_done, resp_err, Firstout, Dout
  );
endinterface

// File: rtl/noc_initiator.sv
// noc_initiator: issues one buffered write or read burst at a time to a NoC device node.
module noc_initiator #(
  parameter logic [3:0] SRC_ID  = 4'd0,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 1024
) (
  input logic            Clk,
  input logic            Reset_n,
  noc_initiator_if.master bus
);
  localparam int         AW   = $clog2(MAX_LEN);
  localparam int         TW   = $clog2(TIMEOUT + 1);
  localparam logic [4:0] MAXL = 5'(MAX_LEN);
  typedef enum logic [2:0] {IDLE, FILL, CMD, WDATA, WAIT, RDATA, DONE} state_t;
  state_t        state, state_n;
  logic          write_q, write_n;
  logic [3:0]    dev_q, dev_n;
  logic [2:0]    reg_q, reg_n;
  logic [4:0]    len_q, len_n;
  logic [4:0]    cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          err_q, err_n;
  logic          mem_we;
  logic [63:0]   mem [MAX_LEN];
  logic          accept, bad_len;
  logic          req_ready_n, wr_ready_n, rd_valid_n, rd_last_n, resp_done_n, resp_err_n, first_n;
  logic [63:0]   rd_data_n, dout_n;
  assign accept  = bus.req_valid && bus.req_ready;
  assign bad_len = bus.req_len == 5'd0 || bus.req_len > MAXL;
  always_comb begin
    state_n     = state;
    write_n     = write_q;
    dev_n       = dev_q;
    reg_n       = reg_q;
    len_n       = len_q;
    cnt_n       = cnt;
    tcnt_n      = tcnt;
    err_n       = err_q;
    mem_we      = 1'b0;
    req_ready_n = 1'b0;
    wr_ready_n  = 1'b0;
    rd_valid_n  = 1'b0;
    rd_last_n   = 1'b0;
    rd_data_n   = '0;
    resp_done_n = 1'b0;
    resp_err_n  = 1'b0;
    first_n     = 1'b0;
    dout_n      = '0;
    case (state)
      IDLE: begin
        req_ready_n = !accept;
        if (accept) begin
          write_n = bus.req_write;
          dev_n   = bus.req_dev;
          reg_n   = bus.req_reg;
          len_n   = bus.req_len;
          // An illegal length is rejected straight from IDLE; nothing reaches the link
          resp_done_n = bad_len;
          resp_err_n  = bad_len;
          wr_ready_n  = !bad_len && bus.req_write;
          state_n     = bad_len ? IDLE : bus.req_write ? FILL : CMD;
        end
      end
      FILL: begin
        mem_we     = bus.wr_valid && bus.wr_ready;
        cnt_n      = mem_we ? cnt + 5'd1 : cnt;
        wr_ready_n = cnt_n < len_q;
        state_n    = cnt_n == len_q ? CMD : FILL;
      end
      CMD: begin
        first_n = 1'b1;
        dout_n  = {write_q ? 5'd4 : 5'd2, 3'b0, dev_q, SRC_ID, 3'b0, len_q, 37'b0, reg_q};
        cnt_n   = '0;
        tcnt_n  = '0;
        err_n   = 1'b0;
        state_n = write_q ? WDATA : WAIT;
      end
      WDATA: begin
        dout_n  = mem[cnt[AW-1:0]];
        cnt_n   = cnt + 5'd1;
        state_n = cnt + 5'd1 == len_q ? WAIT : WDATA;
      end
      WAIT: begin
        cnt_n  = '0;
        tcnt_n = tcnt + TW'(1);
        if (bus.Firstin && bus.Din[63:48] == (write_q ? 16'h2827 : 16'h1827)) begin
          state_n = write_q ? DONE : RDATA;
          err_n   = 1'b0;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      RDATA: begin
        // A new packet header inside the burst means the responder broke protocol
        if (bus.Firstin) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          rd_valid_n = 1'b1;
          rd_data_n  = bus.Din;
          cnt_n      = cnt + 5'd1;
          rd_last_n  = cnt + 5'd1 == len_q;
          state_n    = cnt + 5'd1 == len_q ? DONE : RDATA;
        end
      end
      DONE: begin
        resp_done_n = 1'b1;
        resp_err_n  = err_q;
        err_n       = 1'b0;
        cnt_n       = '0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      write_q       <= 1'b0;
      dev_q         <= '0;
      reg_q         <= '0;
      len_q         <= '0;
      cnt           <= '0;
      tcnt          <= '0;
      err_q         <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.wr_ready  <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_last   <= 1'b0;
      bus.resp_done <= 1'b0;
      bus.resp_err  <= 1'b0;
      bus.Firstout  <= 1'b0;
      bus.Dout      <= '0;
    end else begin
      state         <= state_n;
      write_q       <= write_n;
      dev_q         <= dev_n;
      reg_q         <= reg_n;
      len_q         <= len_n;
      cnt           <= cnt_n;
      tcnt          <= tcnt_n;
      err_q         <= err_n;
      bus.req_ready <= req_ready_n;
      bus.wr_ready  <= wr_ready_n;
      bus.rd_valid  <= rd_valid_n;
      bus.rd_data   <= rd_data_n;
      bus.rd_last   <= rd_last_n;
      bus.resp_done <= resp_done_n;
      bus.resp_err  <= resp_err_n;
      bus.Firstout  <= first_n;
      bus.Dout      <= dout_n;
    end
  end
  always_ff @(posedge Clk) begin
    if (mem_we) mem[cnt[AW-1:0]] <= bus.wr_data;
  end
endmodule
